// File: rtl/i2c0_arb_pkg.sv
// Shared types and default sizing for the I2C_0 bus arbiter between the MSS
// and fabric masters.
package i2c0_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_MSS = 2'd1,
        ST_GNT_FAB = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_FILT_CYCLES    = 3;
    localparam int unsigned DEF_IDLE_CYCLES    = 50;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

    // Open-drain enable: the pad is pulled low only when driven with a 0.
    function automatic logic od_enable(input logic oe, input logic m2f);
        return oe & ~m2f;
    endfunction

endpackage

// File: rtl/i2c0_bus_arbiter_if.sv
// Link between the arbiter core and its bus monitor: raw pad readback in,
// filtered levels and bus state out.
interface i2c0_bus_arbiter_if;

    logic scl_y;
    logic sda_y;
    logic clr_busy;
    logic scl_f;
    logic sda_f;
    logic start;
    logic busy;

    modport master (
        output scl_y, sda_y, clr_busy,
        input  scl_f, sda_f, start, busy
    );

    modport slave (
        input  scl_y, sda_y, clr_busy,
        output scl_f, sda_f, start, busy
    );

endinterface

// File: rtl/i2c0_bus_monitor.sv
// Pad synchroniser, glitch filter, START/STOP detection and BUS_BUSY tracking.
module i2c0_bus_monitor
    import i2c0_arb_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    i2c0_bus_arbiter_if.slave    mon
);

    localparam int unsigned FW = $clog2(FILT_CYCLES + 1);

    // Index 0 is SCL, index 1 is SDA throughout.
    logic [1:0]   sync0_q, sync1_q;
    logic [1:0]   filt_q, filt_d;
    logic [1:0]   prev_q;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic         busy_q, busy_d;
    logic         start_det, stop_det;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync0_q <= '1;
            sync1_q <= '1;
            filt_q  <= '1;
            prev_q  <= '1;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            busy_q  <= 1'b0;
        end else begin
            sync0_q <= {mon.sda_y, mon.scl_y};
            sync1_q <= sync0_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            busy_q  <= busy_d;
        end
    end

    // A line's filtered level flips only after FILT_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync1_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILT_CYCLES - 1)) begin
                    filt_d[i] = sync1_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign start_det =  prev_q[1] & ~filt_q[1] & prev_q[0] & filt_q[0];
    assign stop_det  = ~prev_q[1] &  filt_q[1] & prev_q[0] & filt_q[0];

    always_comb begin
        busy_d = busy_q;
        if (mon.clr_busy) begin
            busy_d = 1'b0;
        end else if (start_det) begin
            busy_d = 1'b1;
        end else if (stop_det) begin
            busy_d = 1'b0;
        end
    end

    assign mon.scl_f = filt_q[0];
    assign mon.sda_f = filt_q[1];
    assign mon.start = start_det;
    assign mon.busy  = busy_q;

endmodule

// File: rtl/i2c0_bus_arbiter.sv
// Arbitrates the shared I2C_0 pads between the MSS and fabric masters with
// round-robin grants, bus-idle guard time and stuck-bus timeout.
module i2c0_bus_arbiter
    import i2c0_arb_pkg::*;
#(
    parameter int unsigned FILT_CYCLES    = DEF_FILT_CYCLES,
    parameter int unsigned IDLE_CYCLES    = DEF_IDLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic FAB_CCC_GL0,
    input  logic FAB_RESET_N,
    input  logic MSS_REQ,
    input  logic FAB_REQ,
    output logic MSS_GNT,
    output logic FAB_GNT,
    input  logic MSS_SCL_M2F,
    input  logic MSS_SCL_M2F_OE,
    input  logic MSS_SDA_M2F,
    input  logic MSS_SDA_M2F_OE,
    input  logic FAB_SCL_M2F,
    input  logic FAB_SCL_M2F_OE,
    input  logic FAB_SDA_M2F,
    input  logic FAB_SDA_M2F_OE,
    output logic MSS_SCL_F2M,
    output logic MSS_SDA_F2M,
    output logic FAB_SCL_F2M,
    output logic FAB_SDA_F2M,
    output logic PAD_SCL_D,
    output logic PAD_SCL_E,
    output logic PAD_SDA_D,
    output logic PAD_SDA_E,
    input  logic PAD_SCL_Y,
    input  logic PAD_SDA_Y,
    output logic BUS_BUSY,
    output logic TIMEOUT_ERR
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  to_q, to_d;
    logic           last_fab_q, last_fab_d;
    logic           tmo_err_q;
    logic           busy, start, scl_f, sda_f;
    logic           in_grant, idle_ok, rel_done, timeout_hit;

    i2c0_bus_arbiter_if u_mon_if ();

    assign u_mon_if.scl_y    = PAD_SCL_Y;
    assign u_mon_if.sda_y    = PAD_SDA_Y;
    assign u_mon_if.clr_busy = timeout_hit;
    assign scl_f = u_mon_if.scl_f;
    assign sda_f = u_mon_if.sda_f;
    assign start = u_mon_if.start;
    assign busy  = u_mon_if.busy;

    i2c0_bus_monitor #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_monitor (
        .clk_i  (FAB_CCC_GL0),
        .rst_ni (FAB_RESET_N),
        .mon    (u_mon_if.slave)
    );

    assign in_grant    = (state_q == ST_GNT_MSS) || (state_q == ST_GNT_FAB);
    assign idle_ok     = (cnt_q == IW'(IDLE_CYCLES));
    assign rel_done    = (cnt_q == IW'(IDLE_CYCLES - 1));
    assign timeout_hit = in_grant && busy && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_ok && (MSS_REQ || FAB_REQ)) begin
                    if (MSS_REQ && (!FAB_REQ || last_fab_q)) begin
                        state_d = ST_GNT_MSS;
                    end else begin
                        state_d = ST_GNT_FAB;
                    end
                end
            end
            ST_GNT_MSS: begin
                if (timeout_hit || (!MSS_REQ && !busy)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_GNT_FAB: begin
                if (timeout_hit || (!FAB_REQ && !busy)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rel_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pads and returns follow the registered state, so reset releases them asynchronously.
    always_comb begin
        MSS_GNT     = 1'b0;
        FAB_GNT     = 1'b0;
        PAD_SCL_D   = 1'b0;
        PAD_SDA_D   = 1'b0;
        PAD_SCL_E   = 1'b0;
        PAD_SDA_E   = 1'b0;
        MSS_SCL_F2M = 1'b1;
        MSS_SDA_F2M = 1'b1;
        FAB_SCL_F2M = 1'b1;
        FAB_SDA_F2M = 1'b1;
        case (state_q)
            ST_GNT_MSS: begin
                MSS_GNT     = 1'b1;
                PAD_SCL_E   = od_enable(MSS_SCL_M2F_OE, MSS_SCL_M2F);
                PAD_SDA_E   = od_enable(MSS_SDA_M2F_OE, MSS_SDA_M2F);
                MSS_SCL_F2M = scl_f;
                MSS_SDA_F2M = sda_f;
            end
            ST_GNT_FAB: begin
                FAB_GNT     = 1'b1;
                PAD_SCL_E   = od_enable(FAB_SCL_M2F_OE, FAB_SCL_M2F);
                PAD_SDA_E   = od_enable(FAB_SDA_M2F_OE, FAB_SDA_M2F);
                FAB_SCL_F2M = scl_f;
                FAB_SDA_F2M = sda_f;
            end
            default: ;
        endcase
    end

    // One counter serves both the IDLE guard time and the RELEASE duration.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (busy || start) begin
                        cnt_d = '0;
                    end else if (!idle_ok) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: cnt_d = cnt_q + 1'b1;
                default:    cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        to_d = '0;
        if (in_grant && (state_d == state_q) && busy) begin
            to_d = (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + 1'b1;
        end
    end

    always_comb begin
        last_fab_d = last_fab_q;
        if (state_d == ST_GNT_FAB) begin
            last_fab_d = 1'b1;
        end else if (state_d == ST_GNT_MSS) begin
            last_fab_d = 1'b0;
        end
    end

    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            cnt_q      <= '0;
            to_q       <= '0;
            last_fab_q <= 1'b1;
            tmo_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            last_fab_q <= last_fab_d;
            tmo_err_q  <= timeout_hit;
        end
    end

    assign BUS_BUSY    = busy;
    assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_i2c0_bus_arbiter.sv
// Directed self-checking bench for i2c0_bus_arbiter with a wired-AND pad model.
module tb_i2c0_bus_arbiter;

    localparam int unsigned FILT = 3;
    localparam int unsigned IDLE = 50;
    localparam int unsigned TMO  = 200;   // scaled-down stuck-bus limit

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic mss_req, fab_req;
    logic mss_scl_m2f, mss_scl_oe, mss_sda_m2f, mss_sda_oe;
    logic fab_scl_m2f, fab_scl_oe, fab_sda_m2f, fab_sda_oe;
    logic ext_scl, ext_sda;
    logic MSS_GNT, FAB_GNT;
    logic MSS_SCL_F2M, MSS_SDA_F2M, FAB_SCL_F2M, FAB_SDA_F2M;
    logic PAD_SCL_D, PAD_SCL_E, PAD_SDA_D, PAD_SDA_E;
    logic BUS_BUSY, TIMEOUT_ERR;

    int checks = 0;
    int errors = 0;

    i2c0_bus_arbiter_if pad_if ();

    // Pull-ups plus open-drain pad driver plus an external device that can hold a line low.
    assign pad_if.scl_y    = ~PAD_SCL_E & ext_scl;
    assign pad_if.sda_y    = ~PAD_SDA_E & ext_sda;
    assign pad_if.clr_busy = TIMEOUT_ERR;
    assign pad_if.scl_f    = MSS_SCL_F2M & FAB_SCL_F2M;
    assign pad_if.sda_f    = MSS_SDA_F2M & FAB_SDA_F2M;
    assign pad_if.start    = 1'b0;
    assign pad_if.busy     = BUS_BUSY;

    i2c0_bus_arbiter #(
        .FILT_CYCLES    (FILT),
        .IDLE_CYCLES    (IDLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .FAB_CCC_GL0    (clk),
        .FAB_RESET_N    (rst_n),
        .MSS_REQ        (mss_req),
        .FAB_REQ        (fab_req),
        .MSS_GNT        (MSS_GNT),
        .FAB_GNT        (FAB_GNT),
        .MSS_SCL_M2F    (mss_scl_m2f),
        .MSS_SCL_M2F_OE (mss_scl_oe),
        .MSS_SDA_M2F    (mss_sda_m2f),
        .MSS_SDA_M2F_OE (mss_sda_oe),
        .FAB_SCL_M2F    (fab_scl_m2f),
        .FAB_SCL_M2F_OE (fab_scl_oe),
        .FAB_SDA_M2F    (fab_sda_m2f),
        .FAB_SDA_M2F_OE (fab_sda_oe),
        .MSS_SCL_F2M    (MSS_SCL_F2M),
        .MSS_SDA_F2M    (MSS_SDA_F2M),
        .FAB_SCL_F2M    (FAB_SCL_F2M),
        .FAB_SDA_F2M    (FAB_SDA_F2M),
        .PAD_SCL_D      (PAD_SCL_D),
        .PAD_SCL_E      (PAD_SCL_E),
        .PAD_SDA_D      (PAD_SDA_D),
        .PAD_SDA_E      (PAD_SDA_E),
        .PAD_SCL_Y      (pad_if.scl_y),
        .PAD_SDA_Y      (pad_if.sda_y),
        .BUS_BUSY       (BUS_BUSY),
        .TIMEOUT_ERR    (TIMEOUT_ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int max);
        for (int i = 0; i < max; i++) begin
            if (MSS_GNT || FAB_GNT) break;
            tick(1);
        end
    endtask

    int  n;
    int  pulses;
    logic seen;

    initial begin
        mss_req = 1'b1; fab_req = 1'b0;
        mss_scl_m2f = 1'b0; mss_scl_oe = 1'b0; mss_sda_m2f = 1'b0; mss_sda_oe = 1'b0;
        fab_scl_m2f = 1'b0; fab_scl_oe = 1'b0; fab_sda_m2f = 1'b0; fab_sda_oe = 1'b0;
        ext_scl = 1'b1; ext_sda = 1'b1;
        tick(3);

        // Reset state
        check("rst_gnt",  {MSS_GNT, FAB_GNT}, 2'b00);
        check("rst_pad",  {PAD_SCL_E, PAD_SDA_E, PAD_SCL_D, PAD_SDA_D}, 4'h0);
        check("rst_stat", {BUS_BUSY, TIMEOUT_ERR}, 2'b00);
        check("rst_f2m",  {MSS_SCL_F2M, MSS_SDA_F2M, FAB_SCL_F2M, FAB_SDA_F2M}, 4'hF);

        // Single MSS request on an idle bus: grant IDLE+1 clocks after reset release
        rst_n = 1'b1;
        tick(IDLE);
        check("gnt_early", {MSS_GNT, FAB_GNT}, 2'b00);
        tick(1);
        check("gnt_mss", {MSS_GNT, FAB_GNT}, 2'b10);
        check("gnt_f2m_hi", {MSS_SCL_F2M, MSS_SDA_F2M, FAB_SCL_F2M, FAB_SDA_F2M}, 4'hF);
        mss_sda_oe = 1'b1;
        #1;
        check("od_sda", {PAD_SCL_E, PAD_SDA_E, PAD_SCL_D, PAD_SDA_D}, 4'b0100);
        tick(8);
        check("start_busy", BUS_BUSY, 1'b1);
        check("f2m_owner", {MSS_SDA_F2M, FAB_SDA_F2M}, 2'b01);

        // Owner drops REQ mid-transaction; the other master's drive is ignored
        mss_scl_oe = 1'b1;
        mss_req = 1'b0;
        fab_req = 1'b1;
        fab_scl_oe = 1'b1;
        tick(20);
        check("hold_gnt", {MSS_GNT, FAB_GNT}, 2'b10);
        check("hold_scl", PAD_SCL_E, 1'b1);
        mss_scl_oe = 1'b0;
        #1;
        check("nonowner_ign", PAD_SCL_E, 1'b0);
        tick(8);
        mss_sda_oe = 1'b0;   // STOP
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (!MSS_GNT) begin seen = 1'b1; break; end
        end
        check("stop_release", seen, 1'b1);
        check("rel_pad", {PAD_SCL_E, PAD_SDA_E}, 2'b00);
        check("rel_f2m", {MSS_SCL_F2M, MSS_SDA_F2M, FAB_SCL_F2M, FAB_SDA_F2M}, 4'hF);
        check("rel_busy", BUS_BUSY, 1'b0);
        // RELEASE (IDLE clocks) then the IDLE guard (IDLE clocks) then the grant edge
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            n++;
            if (FAB_GNT) break;
        end
        check("rel_len", n, 2 * IDLE + 1);
        check("gnt_fab", {MSS_GNT, FAB_GNT}, 2'b01);
        check("fab_scl", PAD_SCL_E, 1'b1);
        fab_scl_oe = 1'b0;
        fab_req = 1'b0;
        tick(5);

        // Simultaneous requests twice: MSS after reset, then FAB
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        mss_req = 1'b1; fab_req = 1'b1;
        wait_grant(200);
        check("rr_first", {MSS_GNT, FAB_GNT}, 2'b10);
        mss_req = 1'b0; fab_req = 1'b0;
        tick(3);
        check("rr_drop", {MSS_GNT, FAB_GNT}, 2'b00);
        mss_req = 1'b1; fab_req = 1'b1;
        wait_grant(300);
        check("rr_second", {MSS_GNT, FAB_GNT}, 2'b01);
        mss_req = 1'b0; fab_req = 1'b0;
        tick(5);

        // 2-clock SDA glitch is filtered; a 3-clock low is a real START/STOP
        ext_sda = 1'b0;
        tick(2);
        ext_sda = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen = seen | BUS_BUSY;
        end
        check("glitch2", seen, 1'b0);
        ext_sda = 1'b0;
        tick(3);
        ext_sda = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            seen = seen | BUS_BUSY;
        end
        check("glitch3", seen, 1'b1);
        check("glitch3_end", BUS_BUSY, 1'b0);

        // Stuck bus under an MSS grant (last grant was FAB)
        mss_req = 1'b1;
        wait_grant(300);
        check("tmo_gnt", {MSS_GNT, FAB_GNT}, 2'b10);
        mss_sda_oe = 1'b1;
        ext_sda = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (BUS_BUSY) break;
        end
        check("tmo_busy", BUS_BUSY, 1'b1);
        n = 0;
        for (int i = 0; i < 2 * TMO; i++) begin
            tick(1);
            n++;
            if (TIMEOUT_ERR) break;
        end
        check("tmo_len", n, TMO);
        check("tmo_err", TIMEOUT_ERR, 1'b1);
        check("tmo_gnt0", {MSS_GNT, FAB_GNT}, 2'b00);
        check("tmo_pad", {PAD_SCL_E, PAD_SDA_E}, 2'b00);
        check("tmo_busy0", BUS_BUSY, 1'b0);
        mss_req = 1'b0;
        tick(1);
        check("tmo_pulse", TIMEOUT_ERR, 1'b0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (TIMEOUT_ERR) pulses++;
        end
        check("tmo_once", pulses, 0);
        mss_sda_oe = 1'b0;
        ext_sda = 1'b1;
        tick(IDLE);

        // Reset during a fabric transfer releases the pads without a clock edge
        fab_req = 1'b1;
        wait_grant(300);
        check("x_gnt_fab", {MSS_GNT, FAB_GNT}, 2'b01);
        fab_sda_oe = 1'b1;
        tick(8);
        fab_scl_oe = 1'b1;
        tick(2);
        check("x_pad", {PAD_SCL_E, PAD_SDA_E}, 2'b11);
        check("x_busy", BUS_BUSY, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pad", {PAD_SCL_E, PAD_SDA_E}, 2'b00);
        check("arst_gnt", {MSS_GNT, FAB_GNT}, 2'b00);
        check("arst_stat", {BUS_BUSY, TIMEOUT_ERR}, 2'b00);
        check("arst_f2m", {MSS_SCL_F2M, MSS_SDA_F2M, FAB_SCL_F2M, FAB_SDA_F2M}, 4'hF);
        fab_sda_oe = 1'b0;
        fab_scl_oe = 1'b0;
        mss_req = 1'b1;
        fab_req = 1'b1;
        tick(2);
        rst_n = 1'b1;
        wait_grant(200);
        check("arst_rr", {MSS_GNT, FAB_GNT}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c0_bus_arbiter.md
I2C0_BUS_ARBITER -- requirements
Module: i2c0_bus_arbiter

Interface
REQ-001 The module SHALL have parameter FILT_CYCLES, default 3, meaning pad-input glitch-filter depth in clocks.
REQ-002 The module SHALL have parameter IDLE_CYCLES, default 50, meaning the bus-free clocks required before any grant change.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum clocks the bus may stay busy under one grant.
REQ-004 The module SHALL have port FAB_CCC_GL0, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 The module SHALL have port FAB_RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have ports MSS_REQ and FAB_REQ, inputs, 1 bit each: bus-ownership requests from the MSS I2C_0 and the fabric I2C master.
REQ-007 The module SHALL have ports MSS_GNT and FAB_GNT, outputs, 1 bit each: the ownership grants.
REQ-008 The module SHALL have ports MSS_SCL_M2F, MSS_SCL_M2F_OE, MSS_SDA_M2F and MSS_SDA_M2F_OE, inputs, 1 bit each: MSS drive data and enables.
REQ-009 The module SHALL have ports FAB_SCL_M2F, FAB_SCL_M2F_OE, FAB_SDA_M2F and FAB_SDA_M2F_OE, inputs, 1 bit each: fabric drive data and enables.
REQ-010 The module SHALL have ports MSS_SCL_F2M, MSS_SDA_F2M, FAB_SCL_F2M and FAB_SDA_F2M, outputs, 1 bit each: bus levels returned to each master.
REQ-011 The module SHALL have ports PAD_SCL_D, PAD_SCL_E, PAD_SDA_D and PAD_SDA_E, outputs, 1 bit each: BIBUF data and enable.
REQ-012 The module SHALL have ports PAD_SCL_Y and PAD_SDA_Y, inputs, 1 bit each: BIBUF pad readback.
REQ-013 The module SHALL have port BUS_BUSY, output, 1 bit: an I2C transaction is in progress.
REQ-014 The module SHALL have port TIMEOUT_ERR, output, 1 bit: one-clock pulse when a stuck bus is forcibly released.

Function
REQ-015 PAD_SCL_Y and PAD_SDA_Y SHALL be synchronised through 2 flops, then filtered; the filtered level SHALL change only after FILT_CYCLES consecutive equal samples.
REQ-016 START (filtered SDA 1->0 while SCL=1) SHALL set BUS_BUSY on the next clock; STOP (SDA 0->1 while SCL=1) SHALL clear it; a repeated START SHALL leave it set.
REQ-017 The FSM states SHALL be IDLE, GNT_MSS, GNT_FAB and RELEASE.
REQ-018 IDLE: once BUS_BUSY=0 has held for IDLE_CYCLES and at least one REQ is high, the FSM SHALL grant; MSS_GNT or FAB_GNT SHALL assert on the following clock.
REQ-019 If both REQs are high in IDLE, the FSM SHALL grant the master not granted last (round-robin); after reset, MSS SHALL win.
REQ-020 In GNT_x: PAD_*_D SHALL be constant 0 (open-drain); PAD_*_E SHALL equal owner_*_OE AND NOT owner_*_M2F, combinationally.
REQ-021 The owner's *_F2M outputs SHALL carry the filtered pad levels; the non-owner's *_F2M outputs SHALL be held at 1, and its M2F/OE inputs SHALL be ignored.
REQ-022 GNT_x SHALL go to RELEASE only when owner REQ=0 and BUS_BUSY=0; a REQ dropped mid-transaction SHALL keep the grant until STOP.
REQ-023 If BUS_BUSY stays 1 for TIMEOUT_CYCLES in GNT_x, the FSM SHALL pulse TIMEOUT_ERR, clear BUS_BUSY, drop the grant and enter RELEASE.
REQ-024 In RELEASE and IDLE: both GNTs SHALL be 0, all PAD_*_E SHALL be 0, and all *_F2M SHALL be 1.
REQ-025 RELEASE SHALL last exactly IDLE_CYCLES clocks, then go to IDLE.
REQ-026 The IDLE_CYCLES counter SHALL restart on any START.
REQ-027 The timeout counter SHALL saturate and SHALL restart on each new grant.
REQ-028 At most one GNT SHALL ever be high.

Reset
REQ-029 While FAB_RESET_N=0, the FSM SHALL be IDLE.
REQ-030 While FAB_RESET_N=0, both GNTs, all PAD_*_E and PAD_*_D, BUS_BUSY and TIMEOUT_ERR SHALL be 0.
REQ-031 While FAB_RESET_N=0, all *_F2M outputs SHALL be 1, filter state SHALL be 1, all counters SHALL be 0, and the last-grant flag SHALL select FAB.
REQ-032 Reset asserted mid-transaction SHALL release the pads immediately, asynchronously.

Structure
REQ-033 Package i2c0_arb_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 Sub-module i2c0_bus_monitor SHALL contain the synchroniser, filter, START/STOP detection and BUS_BUSY.

Verification
REQ-035 Bench: MSS_REQ=1 on an idle bus -> MSS_GNT=1 IDLE_CYCLES+1 clocks after reset release; the MSS open-drain low appears on PAD_SDA_E.
REQ-036 Bench: both REQs high at once, twice in sequence -> grants go MSS, then FAB.
REQ-037 Bench: owner drops REQ between START and STOP -> GNT is held until STOP, then RELEASE lasts 50 clocks.
REQ-038 Bench: 2-clock SDA glitch with FILT_CYCLES=3 -> no START detected and BUS_BUSY stays 0.
REQ-039 Bench: SDA held low after START for 100000 clocks -> one TIMEOUT_ERR pulse, all PAD_*_E=0, GNT=0.
REQ-040 Bench: reset pulsed during an FAB transfer -> PAD_*_E=0 asynchronously; after reset, MSS_REQ and FAB_REQ together grant MSS.
